// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the colour/board pipeline.
//   hsync, vsync  : sync pulses (polarity set by the generator)
//   blank_n       : 1 while the current pixel is visible
//   row, column   : visible line / pixel index (0 outside the visible area)
//   pixel_tick    : last system-clock cycle of the current pixel
//   line_start    : first cycle of pixel 0 of every line
//   frame_start   : first cycle of pixel (0,0) of every frame
// master drives the bundle, slave consumes it.
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic [8:0] row;
  logic [9:0] column;
  logic       pixel_tick;
  logic       line_start;
  logic       frame_start;

  modport master (
    output hsync, vsync, blank_n, row, column, pixel_tick, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, blank_n, row, column, pixel_tick, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A system-clock divider produces the pixel rate; a free-running horizontal/vertical
// counter pair walks the full raster (active + porches + sync). Every output is a
// register holding the decode of the previous cycle's (divider, h, v) state, so all
// outputs share a fixed one-cycle latency and are glitch-free.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active high
//   vga  : timing bundle (master side), see vga_timing_gen_if
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds: H_ACTIVE and the sync edges may equal 1024.
  localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] d_q, d_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic [8:0] row_q, row_d;
  logic [9:0] column_q, column_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  logic tick;
  logic h_wrap;
  logic h_vis, v_vis;
  logic hs_act, vs_act;

  always_comb begin
    tick   = (d_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);

    d_d = tick ? '0 : d_q + DW'(1);
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
    end

    h_vis  = ({1'b0, h_q} < H_VIS_END);
    v_vis  = ({1'b0, v_q} < V_VIS_END);
    hs_act = ({1'b0, h_q} >= HS_BEGIN) && ({1'b0, h_q} < HS_END);
    // v only moves on an h wrap, so vsync can only change alongside h=0.
    vs_act = ({1'b0, v_q} >= VS_BEGIN) && ({1'b0, v_q} < VS_END);

    blank_n_d     = h_vis && v_vis;
    column_d      = h_vis ? h_q : '0;
    row_d         = v_vis ? v_q[8:0] : '0;
    hsync_d       = hs_act ? HS_POL : ~HS_POL;
    vsync_d       = vs_act ? VS_POL : ~VS_POL;
    pixel_tick_d  = tick;
    line_start_d  = (h_q == '0) && (d_q == '0);
    frame_start_d = (h_q == '0) && (v_q == '0) && (d_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q           <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_n_q     <= 1'b0;
      row_q         <= '0;
      column_q      <= '0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      d_q           <= d_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      row_q         <= row_d;
      column_q      <= column_d;
      pixel_tick_q  <= pixel_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank_n     = blank_n_q;
  assign vga.row         = row_q;
  assign vga.column      = column_q;
  assign vga.pixel_tick  = pixel_tick_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three instances (defaults, a tiny
// CLK_DIV=1 raster, and an inverted-polarity CLK_DIV=3 raster) compared against
// an arithmetic raster model indexed by cycles since reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (ifa)
  );

  vga_timing_gen #(
    .CLK_DIV  (1),
    .H_ACTIVE (4),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (3),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (ifb)
  );

  vga_timing_gen #(
    .CLK_DIV  (3),
    .H_ACTIVE (6),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (1),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1)
  ) dut_c (
    .clk (clk),
    .rst (rst_c),
    .vga (ifc)
  );

  // {hsync, vsync, blank_n, row[8:0], column[9:0], pixel_tick, line_start, frame_start}
  logic [24:0] obs_a, obs_b, obs_c;
  assign obs_a = {ifa.hsync, ifa.vsync, ifa.blank_n, ifa.row, ifa.column,
                  ifa.pixel_tick, ifa.line_start, ifa.frame_start};
  assign obs_b = {ifb.hsync, ifb.vsync, ifb.blank_n, ifb.row, ifb.column,
                  ifb.pixel_tick, ifb.line_start, ifb.frame_start};
  assign obs_c = {ifc.hsync, ifc.vsync, ifc.blank_n, ifc.row, ifc.column,
                  ifc.pixel_tick, ifc.line_start, ifc.frame_start};

  // Expected outputs k cycles after release (k=0 is the first cycle with rst low).
  // Output at cycle k shows raster time t=k-1: pixel t/cd, sub-cycle t%cd.
  function automatic logic [24:0] model(input int k, input int cd,
                                        input int ha, input int hfp, input int hs,
                                        input int hbp, input int va, input int vfp,
                                        input int vs, input int vbp,
                                        input bit hp, input bit vp);
    int t, p, sub, h, v, ht, vt;
    logic hsy, vsy, bl;
    logic [8:0] r;
    logic [9:0] c;
    if (k <= 0) return {~hp, ~vp, 1'b0, 9'd0, 10'd0, 3'b000};
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    t   = k - 1;
    p   = t / cd;
    sub = t % cd;
    h   = p % ht;
    v   = (p / ht) % vt;
    bl  = (h < ha) && (v < va);
    c   = (h < ha) ? 10'(h) : 10'd0;
    r   = (v < va) ? 9'(v) : 9'd0;
    hsy = (h >= ha + hfp && h < ha + hfp + hs) ? hp : ~hp;
    vsy = (v >= va + vfp && v < va + vfp + vs) ? vp : ~vp;
    return {hsy, vsy, bl, r, c, sub == cd - 1, h == 0 && sub == 0,
            h == 0 && v == 0 && sub == 0};
  endfunction

  function automatic logic [24:0] exp_a(input int k);
    return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  function automatic logic [24:0] exp_b(input int k);
    return model(k, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
  endfunction

  function automatic logic [24:0] exp_c(input int k);
    return model(k, 3, 6, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1);
  endfunction

  // Holds reset for n sampled edges; returns at the negedge of cycle 0.
  task automatic do_reset(input int which, input int n);
    @(negedge clk);
    case (which)
      0: rst_a = 1'b1;
      1: rst_b = 1'b1;
      default: rst_c = 1'b1;
    endcase
    repeat (n) @(negedge clk);
    case (which)
      0: rst_a = 1'b0;
      1: rst_b = 1'b0;
      default: rst_c = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    do_reset(0, 2);
    tests++;
    if (obs_a !== exp_a(0)) begin
      fails++;
      $display("FAIL reset_vec: got %h want %h", obs_a, exp_a(0));
    end
    tests++;
    if ({ifa.hsync, ifa.vsync, ifa.blank_n, ifa.pixel_tick, ifa.line_start,
         ifa.frame_start} !== 6'b110000 || ifa.row !== 9'd0 || ifa.column !== 10'd0) begin
      fails++;
      $display("FAIL reset_const: got %h want hs=1 vs=1 rest 0", obs_a);
    end
    @(negedge clk);
    tests++;
    if ({ifa.blank_n, ifa.line_start, ifa.frame_start, ifa.pixel_tick} !== 4'b1110 ||
        ifa.row !== 9'd0 || ifa.column !== 10'd0) begin
      fails++;
      $display("FAIL cycle1: got %h want blank_n=1 ls=1 fs=1 pt=0 (0,0)", obs_a);
    end
    @(negedge clk);
    tests++;
    if (ifa.pixel_tick !== 1'b1 || ifa.column !== 10'd0 || ifa.line_start !== 1'b0) begin
      fails++;
      $display("FAIL cycle2: got %h want pt=1 col=0 ls=0", obs_a);
    end
    @(negedge clk);
    tests++;
    if (ifa.column !== 10'd1 || ifa.line_start !== 1'b0 || ifa.frame_start !== 1'b0) begin
      fails++;
      $display("FAIL cycle3: got %h want col=1 strobes 0", obs_a);
    end
  endtask

  task automatic test_random_run();
    int which, rl, len;
    logic [24:0] o, e;
    for (int it = 0; it < 6; it++) begin
      which = int'($urandom_range(0, 2));
      rl    = int'($urandom_range(1, 4));
      len   = (which == 0) ? int'($urandom_range(1500, 3000)) : int'($urandom_range(50, 400));
      do_reset(which, rl);
      for (int k = 0; k <= len; k++) begin
        if (k > 0) @(negedge clk);
        case (which)
          0: begin o = obs_a; e = exp_a(k); end
          1: begin o = obs_b; e = exp_b(k); end
          default: begin o = obs_c; e = exp_c(k); end
        endcase
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL random_run dut%0d k=%0d: got %h want %h", which, k, o, e);
          break;
        end
      end
    end
  endtask

  task automatic test_hline();
    int ls_k[$];
    int hs_first, hs_last, hs_len;
    hs_first = -1;
    hs_last  = -1;
    hs_len   = 0;
    do_reset(0, 1);
    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      if (ifa.line_start === 1'b1) ls_k.push_back(k);
      if (k < 1601 && ifa.hsync === 1'b0) begin
        if (hs_first < 0) hs_first = k;
        hs_last = k;
        hs_len++;
      end
      if (k == 1280) begin
        tests++;
        if (ifa.column !== 10'd639 || ifa.blank_n !== 1'b1) begin
          fails++;
          $display("FAIL last_col: got col=%0d blank_n=%b want 639/1", ifa.column, ifa.blank_n);
        end
      end
      if (k == 1281) begin
        tests++;
        if (ifa.column !== 10'd0 || ifa.blank_n !== 1'b0) begin
          fails++;
          $display("FAIL hblank: got col=%0d blank_n=%b want 0/0", ifa.column, ifa.blank_n);
        end
      end
    end
    tests++;
    if (ls_k.size() != 3) begin
      fails++;
      $display("FAIL line_count: got %0d line_starts want 3", ls_k.size());
    end else begin
      tests++;
      if (ls_k[1] - ls_k[0] != 1600 || ls_k[2] - ls_k[1] != 1600) begin
        fails++;
        $display("FAIL line_period: got %0d,%0d want 1600", ls_k[1] - ls_k[0],
                 ls_k[2] - ls_k[1]);
      end
      tests++;
      if (hs_first - ls_k[0] != 1312) begin
        fails++;
        $display("FAIL hsync_start: got %0d want 1312", hs_first - ls_k[0]);
      end
    end
    tests++;
    if (hs_len != 192 || hs_last - hs_first + 1 != 192) begin
      fails++;
      $display("FAIL hsync_width: got %0d (span %0d) want 192", hs_len, hs_last - hs_first + 1);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(0, 1);
    repeat (1401) @(negedge clk);
    tests++;
    if (ifa.hsync !== 1'b0 || ifa.column !== 10'd0 || ifa.blank_n !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_h700: got %h want hsync active in blank", obs_a);
    end
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({ifa.hsync, ifa.vsync, ifa.blank_n, ifa.pixel_tick, ifa.line_start,
           ifa.frame_start} !== 6'b110000 || ifa.row !== 9'd0 || ifa.column !== 10'd0) begin
        fails++;
        $display("FAIL mid_reset%0d: got %h want hs=1 vs=1 rest 0", i, obs_a);
      end
    end
    rst_a = 1'b0;
    tests++;
    if (obs_a !== 25'h1800000) begin
      fails++;
      $display("FAIL mid_rel_c0: got %h want 1800000", obs_a);
    end
    @(negedge clk);
    tests++;
    if ({ifa.blank_n, ifa.line_start, ifa.frame_start, ifa.pixel_tick} !== 4'b1110 ||
        ifa.column !== 10'd0 || ifa.row !== 9'd0) begin
      fails++;
      $display("FAIL mid_rel_c1: got %h want (0,0) with strobes", obs_a);
    end
    @(negedge clk);
    tests++;
    if (ifa.pixel_tick !== 1'b1 || ifa.column !== 10'd0 || ifa.line_start !== 1'b0) begin
      fails++;
      $display("FAIL mid_rel_c2: got %h want pt=1 col=0", obs_a);
    end
    @(negedge clk);
    tests++;
    if (ifa.column !== 10'd1 || ifa.line_start !== 1'b0 || ifa.frame_start !== 1'b0) begin
      fails++;
      $display("FAIL mid_rel_c3: got %h want col=1", obs_a);
    end
  endtask

  task automatic test_small_frame();
    int ls_k[$];
    int fs_k[$];
    int pt_bad, hs_bad, vs_first, vs_cnt, bl_cnt, ph;
    pt_bad   = 0;
    hs_bad   = 0;
    vs_first = -1;
    vs_cnt   = 0;
    bl_cnt   = 0;
    do_reset(1, 1);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      ph = (k - 1) % 8;
      if (ifb.pixel_tick !== 1'b1) pt_bad++;
      if (ifb.line_start === 1'b1) ls_k.push_back(k);
      if (ifb.frame_start === 1'b1) fs_k.push_back(k);
      if (ifb.hsync !== ((ph == 5 || ph == 6) ? 1'b0 : 1'b1)) hs_bad++;
      if (k <= 48 && ifb.vsync === 1'b0) begin
        if (vs_first < 0) vs_first = k;
        vs_cnt++;
      end
      if (k <= 48 && ifb.blank_n === 1'b1) bl_cnt++;
    end
    tests++;
    if (pt_bad != 0) begin
      fails++;
      $display("FAIL small_tick: got %0d cycles without pixel_tick want 0", pt_bad);
    end
    tests++;
    if (ls_k.size() != 13 || ls_k[0] != 1 || ls_k[1] - ls_k[0] != 8) begin
      fails++;
      $display("FAIL small_line: got %0d starts want 13 at period 8", ls_k.size());
    end
    tests++;
    if (fs_k.size() != 3 || fs_k[0] != 1 || fs_k[1] != 49 || fs_k[2] != 97) begin
      fails++;
      $display("FAIL small_frame_period: got %0d starts want 3 at 1,49,97", fs_k.size());
    end
    tests++;
    if (hs_bad != 0) begin
      fails++;
      $display("FAIL small_hsync: got %0d wrong cycles want 0", hs_bad);
    end
    tests++;
    if (vs_first != 33 || vs_cnt != 8) begin
      fails++;
      $display("FAIL small_vsync: got first=%0d len=%0d want 33/8", vs_first, vs_cnt);
    end
    tests++;
    if (bl_cnt != 12) begin
      fails++;
      $display("FAIL small_blank: got %0d visible cycles want 12", bl_cnt);
    end
  endtask

  task automatic test_polarity();
    int hs_first, hs_cnt, vs_first, vs_cnt;
    logic [24:0] e;
    hs_first = -1;
    hs_cnt   = 0;
    vs_first = -1;
    vs_cnt   = 0;
    do_reset(2, 2);
    tests++;
    if (ifc.hsync !== 1'b0 || ifc.vsync !== 1'b0) begin
      fails++;
      $display("FAIL pol_reset: got hs=%b vs=%b want 0/0", ifc.hsync, ifc.vsync);
    end
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      e = exp_c(k);
      if (k <= 36 && ifc.hsync === 1'b1) begin
        if (hs_first < 0) hs_first = k;
        hs_cnt++;
      end
      if (k <= 288 && ifc.vsync === 1'b1) begin
        if (vs_first < 0) vs_first = k;
        vs_cnt++;
      end
      tests++;
      if ({ifc.hsync, ifc.vsync} !== e[24:23]) begin
        fails++;
        $display("FAIL pol_sync k=%0d: got %b%b want %b", k, ifc.hsync, ifc.vsync, e[24:23]);
        break;
      end
    end
    tests++;
    if (hs_first != 25 || hs_cnt != 9) begin
      fails++;
      $display("FAIL pol_hsync: got first=%0d len=%0d want 25/9", hs_first, hs_cnt);
    end
    tests++;
    if (vs_first != 181 || vs_cnt != 72) begin
      fails++;
      $display("FAIL pol_vsync: got first=%0d len=%0d want 181/72", vs_first, vs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_mid_reset();
    test_small_frame();
    test_polarity();
    test_random_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
